// File: rtl/btn_pkg.sv
// Shared constants for the push-button input stage.
// Channel indices match the btn_stable bit order.
package btn_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_JUMP  = 2;
  localparam int BTN_START = 3;
  localparam int N_BTN     = 4;

  // Stable-time requirement expressed in clk cycles.
  function automatic int db_cycles(
    input int clk_hz,
    input int ms
  );
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter
// and debounced level.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = 5,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic stable_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any sample agreeing with the current level restarts the wait.
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (rst) begin
      s1_d     = 1'b0;
      s2_d     = 1'b0;
      stable_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    s1_q     <= s1_d;
    s2_q     <= s2_d;
    stable_q <= stable_d;
    cnt_q    <= cnt_d;
  end

  assign stable     = stable_q;
  assign stable_nxt = stable_d;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the four raw buttons and shapes them into movement
// levels plus a single-cycle start press pulse.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int CLK_HZ      = 65_000_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       btn_jump_raw,
  input  logic       btn_start_raw,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic       buttondown,
  output logic [3:0] btn_stable
);

  localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CNT_W     = $clog2(DB_CYCLES + 1);

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_nxt;

  assign raw[BTN_LEFT]  = btn_left_raw;
  assign raw[BTN_RIGHT] = btn_right_raw;
  assign raw[BTN_JUMP]  = btn_jump_raw;
  assign raw[BTN_START] = btn_start_raw;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (raw[i]),
      .stable     (stable[i]),
      .stable_nxt (stable_nxt[i])
    );
  end

  logic stepleft_q, stepleft_d;
  logic stepright_q, stepright_d;
  logic stepjump_q, stepjump_d;
  logic buttondown_q, buttondown_d;

  // Output flops load from the channels' next level so every
  // output changes on the same edge as the debounced level.
  always_comb begin
    stepleft_d   = stable_nxt[BTN_LEFT] & ~stable_nxt[BTN_RIGHT];
    stepright_d  = stable_nxt[BTN_RIGHT] & ~stable_nxt[BTN_LEFT];
    stepjump_d   = stable_nxt[BTN_JUMP];
    buttondown_d = stable_nxt[BTN_START] & ~stable[BTN_START];
    if (rst) begin
      stepleft_d   = 1'b0;
      stepright_d  = 1'b0;
      stepjump_d   = 1'b0;
      buttondown_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    stepleft_q   <= stepleft_d;
    stepright_q  <= stepright_d;
    stepjump_q   <= stepjump_d;
    buttondown_q <= buttondown_d;
  end

  assign stepleft   = stepleft_q;
  assign stepright  = stepright_q;
  assign stepjump   = stepjump_q;
  assign buttondown = buttondown_q;
  assign btn_stable = stable;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: sliding-window reference model with
// per-cycle compare, directed latency checks and random bouncing.
module tb_btn_conditioner;

  localparam int DB = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0, right = 1'b0, jump = 1'b0, start = 1'b0;
  logic       stepleft, stepright, stepjump, buttondown;
  logic [3:0] btn_stable;

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_left_raw  (left),
    .btn_right_raw (right),
    .btn_jump_raw  (jump),
    .btn_start_raw (start),
    .stepleft      (stepleft),
    .stepright     (stepright),
    .stepjump      (stepjump),
    .buttondown    (buttondown),
    .btn_stable    (btn_stable)
  );

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: a level is accepted once the raw input sampled on
  // DB consecutive edges (ending two edges back) all disagree with it.
  bit [3:0] hist [0:DB];
  bit [3:0] m_st;
  bit       m_l, m_r, m_j, m_bd;
  bit       armed = 1'b0;

  always @(posedge clk) begin
    bit [3:0] nst;
    int ones;
    if (rst) begin
      for (int i = 0; i <= DB; i++) hist[i] = '0;
      m_st  = '0;
      m_l   = 1'b0;
      m_r   = 1'b0;
      m_j   = 1'b0;
      m_bd  = 1'b0;
      armed = 1'b1;
    end else begin
      nst = m_st;
      for (int c = 0; c < 4; c++) begin
        ones = 0;
        for (int i = 1; i <= DB; i++) ones += int'(hist[i][c]);
        if (ones == DB) nst[c] = 1'b1;
        else if (ones == 0) nst[c] = 1'b0;
      end
      m_bd = nst[3] & ~m_st[3];
      m_st = nst;
      m_l  = nst[0] & ~nst[1];
      m_r  = nst[1] & ~nst[0];
      m_j  = nst[2];
      for (int i = DB; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {start, jump, right, left};
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model stepleft", {3'b0, stepleft}, {3'b0, m_l});
      chk("model stepright", {3'b0, stepright}, {3'b0, m_r});
      chk("model stepjump", {3'b0, stepjump}, {3'b0, m_j});
      chk("model buttondown", {3'b0, buttondown}, {3'b0, m_bd});
      chk("model btn_stable", btn_stable, m_st);
      if (buttondown === 1'b1) pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p0;
    logic any;
    int run [4];
    logic [3:0] lv;

    tick(3);
    chk("reset outputs",
        {stepleft, stepright, stepjump, buttondown}, 4'h0);
    chk("reset stable", btn_stable, 4'h0);
    rst = 1'b0;
    tick(3);

    // Left press/release latency
    left = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 6) chk("left rise e6", {3'b0, stepleft}, 4'h0);
      if (e == 7) chk("left rise e7", {3'b0, stepleft}, 4'h1);
    end
    left = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 6) chk("left fall e6", {3'b0, stepleft}, 4'h1);
      if (e == 7) chk("left fall e7", {3'b0, stepleft}, 4'h0);
    end

    // Bouncy start press, then long hold
    p0 = pulses;
    start = 1'b1; tick(1);
    start = 1'b0; tick(1);
    start = 1'b1; tick(1);
    start = 1'b0; tick(1);
    start = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 6) chk("start e6", {3'b0, buttondown}, 4'h0);
      if (e == 7) chk("start e7", {3'b0, buttondown}, 4'h1);
      if (e == 8) chk("start e8", {3'b0, buttondown}, 4'h0);
    end
    chk("bounce one pulse", 4'(pulses - p0), 4'h1);
    p0 = pulses;
    tick(100);
    chk("held no pulse", 4'(pulses - p0), 4'h0);
    start = 1'b0;
    tick(20);
    chk("release no pulse", 4'(pulses - p0), 4'h0);

    // Glitch-only start activity
    p0 = pulses;
    for (int g = 1; g <= 4; g++) begin
      start = 1'b1; tick(g);
      start = 1'b0; tick(2);
    end
    tick(15);
    chk("glitch no pulse", 4'(pulses - p0), 4'h0);

    // Left and right together
    left = 1'b1;
    right = 1'b1;
    tick(10);
    chk("both held steps", {2'b0, stepleft, stepright}, 4'h0);
    chk("both held stable", {2'b0, btn_stable[1:0]}, 4'h3);
    right = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 6) chk("right drop e6", {3'b0, stepleft}, 4'h0);
      if (e == 7) chk("right drop e7", {3'b0, stepleft}, 4'h1);
    end
    left = 1'b0;
    tick(10);

    // Reset in the middle of a start hold
    start = 1'b1;
    tick(15);
    p0 = pulses;
    rst = 1'b1;
    tick(1);
    chk("rst bd", {3'b0, buttondown}, 4'h0);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 6) chk("post-rst e6", {3'b0, buttondown}, 4'h0);
      if (e == 7) chk("post-rst e7", {3'b0, buttondown}, 4'h1);
    end
    chk("post-rst one pulse", 4'(pulses - p0), 4'h1);
    start = 1'b0;
    tick(15);

    // Press / release / press
    p0 = pulses;
    start = 1'b1; tick(20);
    start = 1'b0; tick(20);
    start = 1'b1; tick(20);
    start = 1'b0; tick(20);
    chk("two presses", 4'(pulses - p0), 4'h2);

    // Short jump pulse
    any = 1'b0;
    jump = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick(1);
      any = any | stepjump;
    end
    jump = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick(1);
      any = any | stepjump;
    end
    chk("short jump", {3'b0, any}, 4'h0);

    // Random bouncing on all channels, occasional reset
    for (int c = 0; c < 4; c++) run[c] = 1;
    lv = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        run[c]--;
        if (run[c] <= 0) begin
          lv[c] = ~lv[c];
          run[c] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(6, 20)) :
                   int'($urandom_range(1, 7));
        end
      end
      {start, jump, right, left} = lv;
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    {start, jump, right, left} = 4'h0;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
